// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word fall-through FIFO.
// Optional even-parity frame support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       par_err,
`endif
  input  logic       err_clr,
  output logic       rx_busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP, S_BREAK
  } state_t;

  state_t          state;
  logic            rx_s1, rxs, rxs_d;
  logic [1:0]      prime;
  logic            armed;
  logic [TW-1:0]   tcnt;
  logic [3:0]      scnt;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            push;
  logic            tick, mid, start;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  // prime keeps the reset value of the synchronizer from arming the receiver
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      prime <= {prime[0], 1'b1};
      if (prime[1] && rxs) armed <= 1'b1;
    end
  end

  assign start = (state == S_IDLE) && armed && rxs_d && !rxs;
  assign tick  = (tcnt == TW'(DIV - 1));
  assign mid   = tick && (scnt == 4'd7);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (start) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
      scnt <= scnt + 4'd1;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      if (err_clr) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (err_clr) par_err <= 1'b0;
`endif
      case (state)
        S_IDLE:  if (start) state <= S_START;
        S_START: if (mid) begin
          bitcnt <= '0;
          state  <= rxs ? S_IDLE : S_DATA;
        end
        S_DATA: if (mid) begin
          shreg  <= {rxs, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bitcnt == 3'd7) state <= S_PAR;
`else
          if (bitcnt == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: if (mid) begin
          par_bad <= (rxs != ^shreg);
          if (rxs != ^shreg) par_err <= 1'b1;
          state   <= S_STOP;
        end
`endif
        S_STOP: if (mid) begin
          if (rxs) begin
`ifdef UART_RX_PARITY_EN
            push  <= !par_bad;
`else
            push  <= 1'b1;
`endif
            state <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end
        end
        S_BREAK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != S_IDLE);

  logic [AW:0] wptr, rptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        full, pop, wr;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid = (wptr != rptr);
  assign pop      = rx_valid && rx_ready;
  assign wr       = push && (!full || pop);
  assign rx_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (err_clr) overrun <= 1'b0;
      if (push && full && !pop) overrun <= 1'b1;
      if (wr) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (432 clocks per bit).
module tb_uart_rx_fifo;
  localparam int BT = 432;

  logic       clk = 1'b0;
  logic       rstn, rxd, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  int tests = 0;
  int failed = 0;

  uart_rx_fifo dut (
    .clk(clk), .rstn(rstn), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .par_err(par_err),
`endif
    .err_clr(err_clr), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // caller is 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cyc(BT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(BT);
    end
    rxd = stop;
    cyc(BT);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  vec_t vecs[6];
  int   lat;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};

    rstn = 1'b0; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    cyc(3);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset rx_busy", rx_busy, 0);
    rstn = 1'b1;
    cyc(10);

    // latency of 0x55 on an idle line
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        for (int n = 1; n <= 5000; n++) begin
          @(posedge clk); #1;
          if (rx_valid) begin lat = n; break; end
        end
      end
    join
    chk("latency in window", (lat >= 4105 && lat <= 4109), 1);
    chk("0x55 data", rx_data, 8'h55);
    chk("0x55 frame_err", frame_err, 0);
    cyc(10);
    chk("0x55 busy after", rx_busy, 0);
    pop_one();
    chk("0x55 popped", rx_valid, 0);

    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].din, vecs[i].stop);
      cyc(20);
      chk($sformatf("vec%0d valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_fe);
      if (rx_valid) pop_one();
      clr_err();
    end

    // glitch shorter than half a bit
    rxd = 1'b0;
    cyc(50);
    chk("glitch busy", rx_busy, 1);
    cyc(50);
    rxd = 1'b1;
    cyc(BT);
    chk("glitch busy cleared", rx_busy, 0);
    chk("glitch no push", rx_valid, 0);
    chk("glitch frame_err", frame_err, 0);

    // framing error, clear, then recovery
    send_byte(8'hA3, 1'b0);
    cyc(20);
    chk("ferr set", frame_err, 1);
    chk("ferr no push", rx_valid, 0);
    clr_err();
    chk("ferr cleared", frame_err, 0);
    send_byte(8'h3C, 1'b1);
    cyc(20);
    chk("0x3C valid", rx_valid, 1);
    chk("0x3C data", rx_data, 8'h3C);
    pop_one();

    // overrun: five back-to-back bytes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    cyc(20);
    chk("overrun set", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr drain %0d", i), rx_data, 32'(i));
      pop_one();
    end
    chk("ovr drained empty", rx_valid, 0);
    clr_err();
    chk("overrun cleared", overrun, 0);

    // push and pop in the same cycle while full
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    cyc(20);
    fork
      send_byte(8'h77, 1'b1);
      begin
        cyc(4107);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
      end
    join
    cyc(20);
    chk("full push+pop no overrun", overrun, 0);
    chk("full drain 02", rx_data, 8'h02); pop_one();
    chk("full drain 03", rx_data, 8'h03); pop_one();
    chk("full drain 04", rx_data, 8'h04); pop_one();
    chk("full drain 77", rx_data, 8'h77); pop_one();
    chk("full drained empty", rx_valid, 0);

    // reset in the middle of a frame with rxd low
    send_byte(8'h11, 1'b1);
    cyc(20);
    chk("pre-reset byte held", rx_valid, 1);
    fork
      send_byte(8'h81, 1'b1);
      begin
        cyc(BT * 3 + 100);
        rstn = 1'b0;
        #1;
        chk("midreset rx_valid", rx_valid, 0);
        chk("midreset rx_data", rx_data, 0);
        chk("midreset rx_busy", rx_busy, 0);
        chk("midreset frame_err", frame_err, 0);
        chk("midreset rxd low", rxd, 0);
        cyc(5);
        rstn = 1'b1;
      end
    join
    cyc(BT);
    chk("remainder ignored valid", rx_valid, 0);
    chk("remainder ignored ferr", frame_err, 0);
    chk("remainder ignored busy", rx_busy, 0);
    send_byte(8'h42, 1'b1);
    cyc(20);
    chk("0x42 valid", rx_valid, 1);
    chk("0x42 data", rx_data, 8'h42);
    pop_one();
    chk("0x42 popped", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
